// File: rtl/ir_fetch_unit.sv
// Instruction fetch and instruction register stage for a multicycle CPU.
// Issues one memory read per fetch and holds the returned word until the next fetch.
module ir_fetch_unit #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        mem_rd_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir_out,
   output logic        ir_valid,
   output logic        fetch_busy,
   output logic        fetch_err,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm_16,
   output logic [25:0] jaddr_26
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] wait_cnt, cnt_nx;
   logic [31:0]      ir_nx, addr_nx;
   logic             req_nx, valid_nx, err_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         ir_out     <= '0;
         mem_addr   <= '0;
         mem_rd_req <= 1'b0;
         ir_valid   <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         wait_cnt   <= cnt_nx;
         ir_out     <= ir_nx;
         mem_addr   <= addr_nx;
         mem_rd_req <= req_nx;
         ir_valid   <= valid_nx;
         fetch_err  <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = wait_cnt;
      ir_nx    = ir_out;
      addr_nx  = mem_addr;
      req_nx   = mem_rd_req;
      valid_nx = 1'b0;
      err_nx   = fetch_err;
      unique case (state)
         IDLE: begin
            req_nx = 1'b0;
            if (fetch_req) begin
               err_nx = 1'b0;
               if (pc_in[1:0] != 2'b00) begin
                  err_nx = 1'b1;
               end else begin
                  addr_nx  = pc_in;
                  req_nx   = 1'b1;
                  cnt_nx   = '0;
                  state_nx = BUSY;
               end
            end
         end
         BUSY: begin
            // Flush outranks a same-cycle ack, which outranks the timeout.
            if (flush) begin
               req_nx   = 1'b0;
               state_nx = IDLE;
            end else if (mem_ack) begin
               ir_nx    = mem_rdata;
               valid_nx = 1'b1;
               req_nx   = 1'b0;
               state_nx = IDLE;
            end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
               err_nx   = 1'b1;
               req_nx   = 1'b0;
               state_nx = IDLE;
            end else begin
               cnt_nx = wait_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fetch_busy = (state == BUSY);

   assign opcode   = ir_out[31:26];
   assign rs       = ir_out[25:21];
   assign rt       = ir_out[20:16];
   assign rd       = ir_out[15:11];
   assign shamt    = ir_out[10:6];
   assign funct    = ir_out[5:0];
   assign imm_16   = ir_out[15:0];
   assign jaddr_26 = ir_out[25:0];

endmodule
